// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_cmd_pkg
// Brief   : Shared state encoding, error codes and checksum for the command link
// Rev     : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_OP  = 3'd1,
        GET_X   = 3'd2,
        GET_Y   = 3'd3,
        GET_CHK = 3'd4
    } state_t;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_CHKSUM  = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

    function automatic logic [7:0] packetChecksum(input logic [7:0] op,
                                                  input logic [7:0] x,
                                                  input logic [7:0] y);
        return op ^ x ^ y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_cmd_if
// Brief     : Receiver byte input, command holding-register handshake and status
// Rev       : 1.0  initial release
// ============================================================================
interface uart_cmd_if;

    logic       rx_data_ready;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        input  rx_data_ready, rx_data, cmd_ready,
        output cmd_valid, cmd_op, cmd_x, cmd_y, err_pulse, err_code, busy
    );

    modport slave (
        output rx_data_ready, rx_data, cmd_ready,
        input  cmd_valid, cmd_op, cmd_x, cmd_y, err_pulse, err_code, busy
    );

endinterface
`default_nettype wire

// File: rtl/rx_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module : rx_timeout_timer
// Brief  : Inter-byte watchdog; pulses expired on the cycle the limit is reached
// Rev    : 1.0  initial release
// ============================================================================
module rx_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    localparam int                 c_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WIDTH-1:0] c_LAST  = c_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [c_WIDTH-1:0] r_count;

    // A byte arriving on the expiry cycle clears the count and suppresses expiry.
    assign expired = enable && !clear && (r_count == c_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || !enable || expired) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module : uart_cmd_controller
// Brief  : Frames 5-byte command packets, validates them, holds one for game logic
// Rev    : 1.0  initial release
// ============================================================================
module uart_cmd_controller
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter int         GRID_SIZE      = 10,
    parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF_BYTE
) (
    input  wire logic  clock,
    input  wire logic  reset_n,
    uart_cmd_if.master bus
);

    localparam logic [7:0] c_GRID_LIMIT = 8'(GRID_SIZE);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_shadowOp;
    logic [7:0] r_shadowX;
    logic [7:0] r_shadowY;
    logic       r_cmdValid;
    logic [7:0] r_cmdOp;
    logic [3:0] r_cmdX;
    logic [3:0] r_cmdY;
    logic       r_errPulse;
    logic [1:0] r_errCode;
    logic       r_busy;
    logic       w_timerExpired;
    logic       w_accept;
    logic       w_load;
    logic       w_errFire;
    logic [1:0] w_errCode;

    rx_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (bus.rx_data_ready),
        .enable  (r_state != IDLE),
        .expired (w_timerExpired)
    );

    assign w_accept = r_cmdValid && bus.cmd_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_errFire   = 1'b0;
        w_errCode   = ERR_OVERRUN;
        if (bus.rx_data_ready) begin
            case (r_state)
                IDLE:    if (bus.rx_data == SOF_BYTE) w_nextState = GET_OP;
                GET_OP:  w_nextState = GET_X;
                GET_X:   w_nextState = GET_Y;
                GET_Y:   w_nextState = GET_CHK;
                GET_CHK: begin
                    w_nextState = IDLE;
                    if (packetChecksum(r_shadowOp, r_shadowX, r_shadowY) != bus.rx_data) begin
                        w_errFire = 1'b1;
                        w_errCode = ERR_CHKSUM;
                    end else if (r_shadowX >= c_GRID_LIMIT || r_shadowY >= c_GRID_LIMIT) begin
                        w_errFire = 1'b1;
                        w_errCode = ERR_RANGE;
                    end else if (!r_cmdValid || w_accept) begin
                        w_load = 1'b1;
                    end else begin
                        w_errFire = 1'b1;
                        w_errCode = ERR_OVERRUN;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end else if (w_timerExpired) begin
            w_nextState = IDLE;
            w_errFire   = 1'b1;
            w_errCode   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadowOp <= '0;
            r_shadowX  <= '0;
            r_shadowY  <= '0;
        end else if (bus.rx_data_ready) begin
            if (r_state == GET_OP) r_shadowOp <= bus.rx_data;
            if (r_state == GET_X)  r_shadowX  <= bus.rx_data;
            if (r_state == GET_Y)  r_shadowY  <= bus.rx_data;
        end
    end

    // A commit on the acceptance cycle refills the holding register back-to-back.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cmdValid <= 1'b0;
            r_cmdOp    <= '0;
            r_cmdX     <= '0;
            r_cmdY     <= '0;
            r_errPulse <= 1'b0;
            r_errCode  <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (w_load) begin
                r_cmdValid <= 1'b1;
                r_cmdOp    <= r_shadowOp;
                r_cmdX     <= r_shadowX[3:0];
                r_cmdY     <= r_shadowY[3:0];
            end else if (w_accept) begin
                r_cmdValid <= 1'b0;
            end
            r_errPulse <= w_errFire;
            if (w_errFire) r_errCode <= w_errCode;
            r_busy <= (w_nextState != IDLE);
        end
    end

    assign bus.cmd_valid = r_cmdValid;
    assign bus.cmd_op    = r_cmdOp;
    assign bus.cmd_x     = r_cmdX;
    assign bus.cmd_y     = r_cmdY;
    assign bus.err_pulse = r_errPulse;
    assign bus.err_code  = r_errCode;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_cmd_controller
// Brief  : Packet-level reference model with scoreboard queues for the command link
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_controller;

    localparam int TO   = 100;
    localparam int GRID = 10;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    uart_cmd_if bus();

    uart_cmd_controller #(
        .TIMEOUT_CYCLES (TO),
        .GRID_SIZE      (GRID),
        .SOF_BYTE       (8'hA5)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] op;
        logic [3:0] x;
        logic [3:0] y;
    } cmd_t;

    typedef struct {
        int code;
        int at;
    } err_t;

    int         cyc       = 0;
    int         lastByte  = 0;
    int         errors    = 0;
    int         checks    = 0;
    int         readyMode = 0;
    bit         done      = 1'b0;
    bit         modelHeld = 1'b0;
    logic [7:0] pkt[$];
    cmd_t       expCmd[$];
    err_t       expErr[$];

    // Reference model: collects whole packets and judges them by the link rules.
    always @(posedge clock) begin : model
        bit         accept;
        bit         loaded;
        logic [7:0] b;
        cyc++;
        loaded = 1'b0;
        if (!reset_n) begin
            pkt.delete();
            expCmd.delete();
            expErr.delete();
            modelHeld = 1'b0;
        end else begin
            accept = modelHeld && bus.cmd_ready;
            if (bus.rx_data_ready) begin
                b = bus.rx_data;
                if (pkt.size() != 0 || b == 8'hA5) begin
                    pkt.push_back(b);
                    lastByte = cyc;
                end
                if (pkt.size() == 5) begin
                    if ((pkt[1] ^ pkt[2] ^ pkt[3]) != pkt[4])
                        expErr.push_back('{1, cyc});
                    else if (int'(pkt[2]) >= GRID || int'(pkt[3]) >= GRID)
                        expErr.push_back('{2, cyc});
                    else if (modelHeld && !accept)
                        expErr.push_back('{0, cyc});
                    else begin
                        expCmd.push_back('{op: pkt[1], x: pkt[2][3:0], y: pkt[3][3:0]});
                        modelHeld = 1'b1;
                        loaded    = 1'b1;
                    end
                    pkt.delete();
                end
            end else if (pkt.size() != 0 && cyc - lastByte == TO) begin
                expErr.push_back('{3, cyc});
                pkt.delete();
            end
            if (accept && !loaded) modelHeld = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin : monitor
        err_t e;
        if (done) begin
            check("leftover_err", expErr.size(), 0);
            check("leftover_cmd", expCmd.size(), 0);
            check("final_busy", bus.busy, 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end else if (!reset_n) begin
            check("rst_busy", bus.busy, 0);
            check("rst_cmd_valid", bus.cmd_valid, 0);
            check("rst_err_pulse", bus.err_pulse, 0);
        end else begin
            check("busy", bus.busy, pkt.size() != 0);
            check("cmd_valid", bus.cmd_valid, modelHeld);
            if (bus.cmd_valid) begin
                check("cmd_pending", expCmd.size() != 0, 1);
                if (expCmd.size() != 0) begin
                    check("cmd_fields", {bus.cmd_op, bus.cmd_x, bus.cmd_y}, expCmd[0]);
                    if (bus.cmd_ready) void'(expCmd.pop_front());
                end
            end
            if (bus.err_pulse) begin
                check("err_expected", expErr.size() != 0, 1);
                if (expErr.size() != 0) begin
                    e = expErr.pop_front();
                    check("err_code", bus.err_code, e.code);
                    check("err_cycle", cyc, e.at);
                end
            end else if (expErr.size() != 0 && expErr[0].at <= cyc) begin
                e = expErr.pop_front();
                check("err_pulse_missing", bus.err_pulse, 1);
            end
        end
    end

    task automatic step(input logic dr, input logic [7:0] d);
        @(posedge clock);
        #1;
        bus.rx_data_ready = dr;
        bus.rx_data       = d;
        case (readyMode)
            0:       bus.cmd_ready = 1'b0;
            1:       bus.cmd_ready = 1'b1;
            default: bus.cmd_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic sendPkt(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] chk, input int gap);
        step(1'b1, 8'hA5); idle(gap);
        step(1'b1, op);    idle(gap);
        step(1'b1, x);     idle(gap);
        step(1'b1, y);     idle(gap);
        step(1'b1, chk);   idle(gap);
    endtask

    initial begin : stimulus
        int         kind;
        int         gap;
        logic [7:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] chk;
        bus.rx_data_ready = 1'b0;
        bus.rx_data       = 8'h00;
        bus.cmd_ready     = 1'b0;
        idle(3);
        reset_n = 1'b1;

        // Good packet, held for 20 cycles, then accepted
        readyMode = 0;
        sendPkt(8'h01, 8'h03, 8'h04, 8'h06, 0);
        idle(20);
        readyMode = 1;
        idle(3);

        // Checksum and range errors
        sendPkt(8'h01, 8'h03, 8'h04, 8'h07, 0);
        idle(3);
        sendPkt(8'h02, 8'h0A, 8'h00, 8'h08, 0);
        idle(3);

        // Leading garbage is ignored
        step(1'b1, 8'h00); step(1'b1, 8'hFF); step(1'b1, 8'h13);
        sendPkt(8'h05, 8'h01, 8'h01, 8'h05, 0);
        idle(3);

        // Timeout, then a byte landing exactly on the expiry cycle
        step(1'b1, 8'hA5); step(1'b1, 8'h01);
        idle(TO + 20);
        step(1'b1, 8'hA5); step(1'b1, 8'h01);
        idle(TO - 1);
        step(1'b1, 8'h03); step(1'b1, 8'h04); step(1'b1, 8'h06);
        idle(3);

        // Overrun, then back-to-back refill on the acceptance cycle
        readyMode = 0;
        sendPkt(8'h01, 8'h03, 8'h04, 8'h06, 0);
        sendPkt(8'h02, 8'h05, 8'h06, 8'h01, 0);
        idle(3);
        readyMode = 1;
        idle(3);
        readyMode = 0;
        sendPkt(8'h01, 8'h03, 8'h04, 8'h06, 0);
        step(1'b1, 8'hA5); step(1'b1, 8'h02); step(1'b1, 8'h05); step(1'b1, 8'h06);
        readyMode = 1;
        step(1'b1, 8'h01);
        readyMode = 0;
        idle(5);
        readyMode = 1;
        idle(3);

        // Reset mid-packet with a command held
        readyMode = 0;
        sendPkt(8'h01, 8'h03, 8'h04, 8'h06, 0);
        step(1'b1, 8'hA5); step(1'b1, 8'h01); step(1'b1, 8'h03);
        step(1'b0, 8'h00);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        sendPkt(8'h01, 8'h03, 8'h04, 8'h06, 0);
        readyMode = 1;
        idle(3);

        // Randomized packets, errors, garbage and boundary gaps
        readyMode = 2;
        for (int n = 0; n < 250; n++) begin
            kind = int'($urandom_range(0, 9));
            op   = 8'($urandom);
            x    = 8'($urandom_range(0, GRID - 1));
            y    = 8'($urandom_range(0, GRID - 1));
            if (kind == 0) x = 8'($urandom_range(GRID, 255));
            if (kind == 1) y = 8'($urandom_range(GRID, 255));
            if (kind == 3) op = 8'hA5;
            chk = op ^ x ^ y;
            if (kind == 2) chk = chk ^ 8'(1 << $urandom_range(0, 7));
            if (kind == 4) step(1'b1, 8'($urandom));
            if ($urandom_range(0, 19) == 0)
                gap = ($urandom_range(0, 1) == 1) ? TO - 1 : TO;
            else
                gap = int'($urandom_range(0, 3));
            sendPkt(op, x, y, chk, gap);
        end

        readyMode = 1;
        idle(TO + 10);
        done = 1'b1;
        repeat (4) @(posedge clock);
        $display("FAIL monitor_stalled: got no summary expected summary");
        $fatal(1);
    end

endmodule
`default_nettype wire
